// File: rtl/dotprod_pkg.sv
// Shared definitions for the dotprod loader: default widths, FSM state codes
// and the element-counter width helper.
package dotprod_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_START = 3'd2;
    localparam state_t ST_RUN   = 3'd3;
    localparam state_t ST_HOLD  = 3'd4;

    // Bits needed to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dotprod_loader_wr.sv
// SRAM write-port driver: a write is issued only on an accepted beat, with
// both SRAMs addressed by the current element count.
module dotprod_loader_wr
    import dotprod_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 5
) (
    input  logic              accept_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ADDR_W-1:0] a_addr_o,
    output logic [DATA_W-1:0] a_d_o,
    output logic              a_we_o,
    output logic [ADDR_W-1:0] b_addr_o,
    output logic [DATA_W-1:0] b_d_o,
    output logic              b_we_o
);

    // Address and data follow the count and inputs; enables follow the handshake.
    always_comb begin
        a_addr_o = ADDR_W'(count_i);
        b_addr_o = ADDR_W'(count_i);
        a_d_o    = a_i;
        b_d_o    = b_i;
        if (accept_i) begin
            a_we_o = 1'b1;
            b_we_o = 1'b1;
        end else begin
            a_we_o = 1'b0;
            b_we_o = 1'b0;
        end
    end

endmodule

// File: rtl/dotprod_loader.sv
// Loads (a,b) pairs into the operand SRAMs, sequences the dotprod core and
// returns its result. Optional RUN watchdog: define DOTPROD_LOADER_TIMEOUT_EN.
module dotprod_loader
    import dotprod_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic [ADDR_W-1:0] a_address1,
    output logic [DATA_W-1:0] a_d1,
    output logic              a_we1,
    output logic [ADDR_W-1:0] b_address1,
    output logic [DATA_W-1:0] b_d1,
    output logic              b_we1,
    output logic              mem_owner,
    output logic              dp_start,
    output logic [31:0]       dp_n,
    input  logic              dp_done,
    input  logic              dp_idle,
    input  logic [DATA_W-1:0] dp_return,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [31:0]       res_len,
    output logic              res_err
);

    localparam int CNT_W = cnt_width(DEPTH);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              dp_start_q, dp_start_d;
    logic              mem_owner_q, mem_owner_d;
    logic              res_valid_q, res_valid_d;
    logic              res_err_q, res_err_d;
    logic [31:0]       dp_n_q, dp_n_d;
    logic [31:0]       res_len_q, res_len_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;

    logic ready_s;
    logic accept_s;
    logic at_max_s;
    logic tmo_hit_s;

    // Gated by reset so no beat can be accepted (and no write issued) in a reset cycle.
    assign ready_s  = ap_rst_n & (state_q == ST_LOAD);
    assign accept_s = in_valid & ready_s;
    assign at_max_s = (count_q == CNT_W'(DEPTH - 1));

`ifdef DOTPROD_LOADER_TIMEOUT_EN
    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Watchdog counts RUN cycles without dp_done and clears elsewhere.
    always_comb begin
        if ((state_q == ST_RUN) && !dp_done) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = '0;
        end
    end

    assign tmo_hit_s = (state_q == ST_RUN) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Sequencer next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        dp_start_d  = dp_start_q;
        mem_owner_d = mem_owner_q;
        res_valid_d = res_valid_q;
        res_err_d   = res_err_q;
        dp_n_d      = dp_n_q;
        res_len_d   = res_len_q;
        res_data_d  = res_data_q;
        case (state_q)
            ST_IDLE: begin
                if (dp_idle) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    count_d = count_q + CNT_W'(1);
                    // A full buffer without in_last closes the vector as an overflow.
                    if (in_last || at_max_s) begin
                        dp_n_d      = 32'(count_q) + 32'd1;
                        ovf_d       = ~in_last;
                        dp_start_d  = 1'b1;
                        mem_owner_d = 1'b1;
                        state_d     = ST_START;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (dp_done) begin
                    res_data_d  = dp_return;
                    res_len_d   = dp_n_q;
                    res_err_d   = ovf_q;
                    dp_start_d  = 1'b0;
                    mem_owner_d = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else if (tmo_hit_s) begin
                    res_data_d  = '0;
                    res_len_d   = dp_n_q;
                    res_err_d   = 1'b1;
                    dp_start_d  = 1'b0;
                    mem_owner_d = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    count_d     = '0;
                    ovf_d       = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            dp_start_q  <= 1'b0;
            mem_owner_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            dp_n_q      <= 32'd0;
            res_len_q   <= 32'd0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            dp_start_q  <= dp_start_d;
            mem_owner_q <= mem_owner_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
            dp_n_q      <= dp_n_d;
            res_len_q   <= res_len_d;
            res_data_q  <= res_data_d;
        end
    end

    dotprod_loader_wr #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_wr (
        .accept_i (accept_s),
        .count_i  (count_q),
        .a_i      (in_a),
        .b_i      (in_b),
        .a_addr_o (a_address1),
        .a_d_o    (a_d1),
        .a_we_o   (a_we1),
        .b_addr_o (b_address1),
        .b_d_o    (b_d1),
        .b_we_o   (b_we1)
    );

    assign in_ready  = ready_s;
    assign mem_owner = mem_owner_q;
    assign dp_start  = dp_start_q;
    assign dp_n      = dp_n_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_len   = res_len_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_dotprod_loader.sv
// Scoreboard bench for dotprod_loader with a behavioural dotprod core and
// SRAM model; define DOTPROD_LOADER_TIMEOUT_EN to exercise the watchdog.
module tb_dotprod_loader;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 16;
    localparam int TMO   = 8;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          in_last = 1'b0;
    logic [AW-1:0] a_address1, b_address1;
    logic [DW-1:0] a_d1, b_d1;
    logic          a_we1, b_we1;
    logic          mem_owner, dp_start;
    logic [31:0]   dp_n;
    logic          dp_done = 1'b0;
    logic          dp_idle;
    logic [DW-1:0] dp_return = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_data;
    logic [31:0]   res_len;
    logic          res_err;

    typedef struct { logic [31:0] addr; logic [31:0] a; logic [31:0] b; } wr_t;
    typedef struct { logic [31:0] data; logic [31:0] len; logic err; } res_t;

    wr_t  wq[$];
    res_t rq[$];
    wr_t  wrm;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] a_mem [DEPTH];
    logic [31:0] b_mem [DEPTH];
    logic [31:0] va [32];
    logic [31:0] vb [32];

    logic        busy = 1'b0;
    logic        suppress_done = 1'b0;
    int          idx = 0;
    int          mdl_n = 0;
    logic [31:0] acc = '0;

    always #5 ap_clk = ~ap_clk;

    dotprod_loader #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .a_address1(a_address1), .a_d1(a_d1), .a_we1(a_we1),
        .b_address1(b_address1), .b_d1(b_d1), .b_we1(b_we1),
        .mem_owner(mem_owner), .dp_start(dp_start), .dp_n(dp_n),
        .dp_done(dp_done), .dp_idle(dp_idle), .dp_return(dp_return),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_len(res_len), .res_err(res_err)
    );

    // SRAM write port: every write must match the next expected beat.
    always @(posedge ap_clk) begin
        if (a_we1 === 1'b1 || b_we1 === 1'b1) begin
            n_cmp++;
            if (wq.size() == 0) begin
                n_bad++;
                $display("FAIL sram_write: unexpected write addr=%0d a=%0d b=%0d", a_address1, a_d1, b_d1);
            end else begin
                wrm = wq.pop_front();
                if (a_we1 !== 1'b1 || b_we1 !== 1'b1 || a_address1 !== wrm.addr || b_address1 !== wrm.addr ||
                    a_d1 !== wrm.a || b_d1 !== wrm.b) begin
                    n_bad++;
                    $display("FAIL sram_write: got we=%b/%b addr=%0d/%0d d=%0d/%0d required addr=%0d d=%0d/%0d",
                             a_we1, b_we1, a_address1, b_address1, a_d1, b_d1, wrm.addr, wrm.a, wrm.b);
                end
            end
            if (a_address1 < DEPTH) begin
                a_mem[a_address1[3:0]] <= a_d1;
                b_mem[b_address1[3:0]] <= b_d1;
            end
        end
    end

    // Behavioural dotprod core: latch n on start, one read per cycle, pulse done.
    always @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            busy    <= 1'b0;
            dp_done <= 1'b0;
        end else if (!busy) begin
            dp_done <= 1'b0;
            if (dp_start === 1'b1 && !dp_done) begin
                n_cmp++;
                if (mem_owner !== 1'b1) begin
                    n_bad++;
                    $display("FAIL owner_at_start: mem_owner=%b required 1", mem_owner);
                end
                busy  <= 1'b1;
                idx   <= 0;
                acc   <= '0;
                mdl_n <= int'(dp_n);
            end
        end else if (idx < mdl_n) begin
            n_cmp++;
            if (mem_owner !== 1'b1) begin
                n_bad++;
                $display("FAIL owner_at_read: mem_owner=%b required 1 at read %0d", mem_owner, idx);
            end
            acc <= acc + a_mem[idx] * b_mem[idx];
            idx <= idx + 1;
        end else if (!suppress_done) begin
            dp_done   <= 1'b1;
            dp_return <= acc;
            busy      <= 1'b0;
        end
    end

    assign dp_idle = ~busy;

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        wq.delete();
        rq.delete();
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
        int w = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        #1;
        while (in_ready !== 1'b1 && w < 100) begin
            @(negedge ap_clk);
            #1;
            w++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL beat_accept: in_ready=%b required 1 within 100 cycles", in_ready);
        end
        @(negedge ap_clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_vector(input int n, input int last_at, input int gap);
        for (int k = 0; k < n; k++) begin
            wq.push_back('{32'(k), va[k], vb[k]});
            send_beat(va[k], vb[k], k == last_at);
            repeat (gap) @(negedge ap_clk);
        end
    endtask

    task automatic get_result(input int hold, input string name);
        res_t e;
        int   w = 0;
        while (res_valid !== 1'b1 && w < 200) begin
            @(negedge ap_clk);
            w++;
        end
        n_cmp++;
        if (res_valid !== 1'b1 || rq.size() == 0) begin
            n_bad++;
            $display("FAIL %s_valid: res_valid=%b required 1 (expected results queued=%0d)", name, res_valid, rq.size());
            return;
        end
        e = rq.pop_front();
        repeat (hold) begin
            @(negedge ap_clk);
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== e.data) begin
                n_bad++;
                $display("FAIL %s_hold: res_valid=%b res_data=%0d required 1 / %0d", name, res_valid, res_data, e.data);
            end
        end
        n_cmp++;
        if (res_data !== e.data || res_len !== e.len || res_err !== e.err || dp_n !== e.len) begin
            n_bad++;
            $display("FAIL %s_result: data=%0d len=%0d err=%b dp_n=%0d required %0d/%0d/%b/%0d",
                     name, res_data, res_len, res_err, dp_n, e.data, e.len, e.err, e.len);
        end
        res_ready = 1'b1;
        @(negedge ap_clk);
        res_ready = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_release: res_valid=%b required 0", name, res_valid);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_a     = 32'd5;
        in_b     = 32'd6;
        repeat (2) @(negedge ap_clk);
        n_cmp++;
        if (in_ready !== 1'b0 || a_we1 !== 1'b0 || b_we1 !== 1'b0 || dp_start !== 1'b0 || mem_owner !== 1'b0 ||
            res_valid !== 1'b0 || res_err !== 1'b0 || res_data !== 32'd0 || res_len !== 32'd0 ||
            dp_n !== 32'd0 || a_address1 !== 32'd0 || b_address1 !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_values: rdy=%b we=%b%b st=%b own=%b rv=%b err=%b data=%0d len=%0d n=%0d addr=%0d required all 0",
                     in_ready, a_we1, b_we1, dp_start, mem_owner, res_valid, res_err, res_data, res_len, dp_n, a_address1);
        end
        in_valid = 1'b0;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_to_load: in_ready=%b required 1", in_ready);
        end
        // Reset asserted while a beat is offered in LOAD.
        ap_rst_n = 1'b0;
        in_valid = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || a_we1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_cycle_write: in_ready=%b a_we1=%b required 0/0", in_ready, a_we1);
        end
        @(negedge ap_clk);
        in_valid = 1'b0;
        ap_rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_to_idle: in_ready=%b required 0", in_ready);
        end
        @(negedge ap_clk);
    endtask

    task automatic test_basic();
        for (int k = 0; k < 10; k++) begin
            va[k] = 32'(k + 1);
            vb[k] = 32'(10 - k);
        end
        rq.push_back('{32'd220, 32'd10, 1'b0});
        send_vector(10, 9, 0);
        get_result(0, "basic");
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (a_mem[k] !== 32'(k + 1) || b_mem[k] !== 32'(10 - k)) begin
                n_bad++;
                $display("FAIL basic_mem[%0d]: a=%0d b=%0d required %0d/%0d", k, a_mem[k], b_mem[k], k + 1, 10 - k);
            end
        end
        n_cmp++;
        if (wq.size() != 0) begin
            n_bad++;
            $display("FAIL basic_writes: %0d writes missing required 0", wq.size());
        end
    endtask

    task automatic test_gapped();
        for (int k = 0; k < DEPTH; k++) begin
            a_mem[k] = '0;
            b_mem[k] = '0;
        end
        rq.push_back('{32'd220, 32'd10, 1'b0});
        send_vector(10, 9, 1);
        get_result(5, "gapped");
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (a_mem[k] !== 32'(k + 1) || b_mem[k] !== 32'(10 - k)) begin
                n_bad++;
                $display("FAIL gapped_mem[%0d]: a=%0d b=%0d required %0d/%0d", k, a_mem[k], b_mem[k], k + 1, 10 - k);
            end
        end
    endtask

    task automatic test_back_to_back();
        rq.push_back('{32'd220, 32'd10, 1'b0});
        send_vector(10, 9, 0);
        get_result(0, "b2b_first");
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_bubble: in_ready=%b required 0 in IDLE", in_ready);
        end
        @(negedge ap_clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_reload: in_ready=%b required 1 after two bubbles", in_ready);
        end
        va[0] = 32'd2;
        vb[0] = 32'd3;
        rq.push_back('{32'd6, 32'd1, 1'b0});
        send_vector(1, 0, 0);
        get_result(0, "b2b_second");
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 18; k++) begin
            va[k] = 32'd1;
            vb[k] = 32'd1;
        end
        rq.push_back('{32'd16, 32'd16, 1'b1});
        send_vector(DEPTH, -1, 0);
        in_valid = 1'b1;
        in_a     = 32'd1;
        in_b     = 32'd1;
        repeat (4) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL ovf_blocked: in_ready=%b required 0 after full buffer", in_ready);
            end
            @(negedge ap_clk);
        end
        in_valid = 1'b0;
        get_result(0, "overflow");
        rq.push_back('{32'd2, 32'd2, 1'b0});
        send_vector(2, 1, 0);
        get_result(0, "ovf_tail");
    endtask

    task automatic test_single();
        va[0] = 32'd7;
        vb[0] = 32'd6;
        rq.push_back('{32'd42, 32'd1, 1'b0});
        send_vector(1, 0, 0);
        get_result(0, "single");
    endtask

    task automatic test_reset_run();
        int w = 0;
        for (int k = 0; k < 10; k++) begin
            va[k] = 32'(k + 1);
            vb[k] = 32'(10 - k);
        end
        send_vector(10, 9, 0);
        while (dp_start !== 1'b1 && w < 20) begin
            @(negedge ap_clk);
            w++;
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        n_cmp++;
        if (dp_start !== 1'b0 || mem_owner !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_in_run: dp_start=%b mem_owner=%b res_valid=%b in_ready=%b required 0/0/0/0",
                     dp_start, mem_owner, res_valid, in_ready);
        end
        ap_rst_n = 1'b1;
        wq.delete();
        va[0] = 32'd3; vb[0] = 32'd5;
        va[1] = 32'd2; vb[1] = 32'd8;
        va[2] = 32'd1; vb[2] = 32'd1;
        rq.push_back('{32'd32, 32'd3, 1'b0});
        send_vector(3, 2, 0);
        get_result(0, "after_reset");
    endtask

    task automatic test_timeout();
        int w = 0;
        int cyc = 0;
        suppress_done = 1'b1;
        va[0] = 32'd3;
        vb[0] = 32'd4;
        send_vector(1, 0, 0);
        while (dp_start !== 1'b1 && w < 20) begin
            @(negedge ap_clk);
            w++;
        end
        while (res_valid !== 1'b1 && cyc < 40) begin
            @(negedge ap_clk);
            cyc++;
        end
`ifdef DOTPROD_LOADER_TIMEOUT_EN
        n_cmp++;
        if (cyc != 9 || dp_start !== 1'b0 || mem_owner !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_latency: cycles=%0d dp_start=%b mem_owner=%b required 9/0/0", cyc, dp_start, mem_owner);
        end
        rq.push_back('{32'd0, 32'd1, 1'b1});
        get_result(0, "timeout");
`else
        n_cmp++;
        if (res_valid !== 1'b0 || dp_start !== 1'b1) begin
            n_bad++;
            $display("FAIL no_timeout: res_valid=%b dp_start=%b required 0/1 after %0d cycles", res_valid, dp_start, cyc);
        end
`endif
        suppress_done = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back();
        test_overflow();
        test_single();
        test_reset_run();
        test_timeout();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/dotprod_loader.md
Name: dotprod_loader

Overview:
- Upstream feeder and sequencer for the dotprod core.
- Accepts a stream of (a,b) element pairs over a valid/ready handshake and writes them into the two operand SRAMs at sequential addresses 0..n-1.
- Then drives dotprod's ap_start with n, waits for ap_done, and presents ap_return plus length on a valid/ready result port.
- Owns SRAM write access during load and hands the SRAMs to dotprod during compute via mem_owner.

Parameters:
- DATA_W, 32, element and result width.
- ADDR_W, 32, SRAM address width, matching dotprod a_address0/b_address0.
- DEPTH, 16, maximum elements per vector; must satisfy 1 <= DEPTH <= 2^ADDR_W.
- TIMEOUT_CYCLES, 1024, watchdog limit in RUN; used only when DOTPROD_LOADER_TIMEOUT_EN is defined.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  element pair valid.
- in_ready  out  1  loader can accept a pair.
- in_a  in  DATA_W  element for SRAM a.
- in_b  in  DATA_W  element for SRAM b.
- in_last  in  1  final pair of the vector.
- a_address1  out  ADDR_W  SRAM a write address.
- a_d1  out  DATA_W  SRAM a write data.
- a_we1  out  1  SRAM a write enable.
- b_address1  out  ADDR_W  SRAM b write address.
- b_d1  out  DATA_W  SRAM b write data.
- b_we1  out  1  SRAM b write enable.
- mem_owner  out  1  0 = loader drives the SRAMs, 1 = dotprod drives them; controls the external mux.
- dp_start  out  1  to dotprod ap_start.
- dp_n  out  32  to dotprod n.
- dp_done  in  1  from dotprod ap_done.
- dp_idle  in  1  from dotprod ap_idle.
- dp_return  in  DATA_W  from dotprod ap_return.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_data  out  DATA_W  dot product.
- res_len  out  32  element count used.
- res_err  out  1  overflow or timeout occurred on this vector.

Behaviour:
- Reset values (ap_rst_n=0 sampled at an edge): state=IDLE, count=0.
  - in_ready, we, dp_start, mem_owner, res_valid, res_err are 0.
  - Addresses, data, dp_n, res_data, res_len are 0.
- Reset mid-operation aborts everything and returns to IDLE in one cycle. No SRAM write is issued in the reset cycle.
- FSM states: IDLE, LOAD, START, RUN, HOLD.
- IDLE:
  - in_ready=0 and mem_owner=0.
  - Moves to LOAD when dp_idle=1, which keeps the handshake honest.
- LOAD:
  - in_ready=1 and mem_owner=0.
  - On each accepted beat (in_valid & in_ready), in the same cycle and combinationally: a_we1=b_we1=1, a_address1=b_address1=count, a_d1=in_a, b_d1=in_b. Then count increments.
  - No write occurs on a cycle without handshake.
  - Beat with in_last=1: dp_n <= count+1, go to START.
  - Beat accepted at count=DEPTH-1 without in_last: treat it as last, dp_n=DEPTH, set overflow flag.
  - Following beats stay unaccepted until the next LOAD.
- START:
  - mem_owner=1 and dp_start=1.
  - Go to RUN next cycle. The one-cycle gap guarantees the mux has switched before dotprod issues reads.
- RUN:
  - dp_start is held at 1 until dp_done is sampled 1 (ap_start level semantics).
  - On dp_done=1: capture dp_return into res_data and dp_n into res_len, set res_err=overflow flag.
  - Same edge: dp_start<=0, mem_owner<=0, res_valid<=1, go to HOLD.
- HOLD:
  - res_valid=1 and outputs stable until res_ready=1.
  - On accept: res_valid<=0, count<=0, flags cleared, go to IDLE.
  - Back-to-back vectors therefore incur 2 bubble cycles (HOLD->IDLE->LOAD).
- Arithmetic: count is ceil(log2(DEPTH+1)) bits, zero-extended to 32 for dp_n/res_len. No arithmetic on data.
- Simultaneous dp_done and reset: reset wins.
- dp_done outside RUN is ignored.

Optional Feature:
- DOTPROD_LOADER_TIMEOUT_EN defined:
  - A cycle counter runs in RUN.
  - If TIMEOUT_CYCLES elapse without dp_done: drop dp_start, set mem_owner=0, res_data=0, res_err=1, go to HOLD.
- Undefined:
  - No counter; RUN waits indefinitely.
  - res_err reflects overflow only.

Decomposition:
- Package dotprod_pkg: state enum (IDLE, LOAD, START, RUN, HOLD), DATA_W/ADDR_W defaults, count-width function.
- One natural sub-module: dotprod_loader_wr, the combinational SRAM write-port driver (address/data/we from handshake and count).
- FSM stays in the top module.

Test Plan:
- Stream pairs (1,10),(2,9)...(10,1), last on beat 10, res_ready=1 -> exactly 10 writes at addresses 0..9, dp_n=10, res_data=220, res_len=10, res_err=0.
- Same vector with in_valid toggled every other cycle and res_ready held 0 for 5 cycles -> identical SRAM contents, res_valid held stable, result 220 accepted only when res_ready rises.
- DEPTH=4, stream 6 beats without last (values (1,1)..) -> 4 writes, beats 5-6 not accepted until the next LOAD, dp_n=4, res_data=4, res_err=1.
- Single beat (7,6) with last -> dp_n=1, res_data=42; check mem_owner=1 one cycle before dotprod's first read.
- Assert ap_rst_n=0 during RUN -> next edge: dp_start=0, mem_owner=0, res_valid=0, state IDLE. A fresh vector afterwards computes correctly.
- With DOTPROD_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=8, dp_done tied 0 -> res_valid after 8 RUN cycles with res_err=1 and res_data=0. Without the macro -> res_valid stays 0.
